// File: rtl/led_fader_pkg.sv
// Shared types and defaults for the LED fader: channel state encoding and
// default PWM resolution / step period.
package led_fader_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        RISE = 2'd1,
        ON   = 2'd2,
        FALL = 2'd3
    } fade_state_e;

    localparam int unsigned PWM_BITS_DEF    = 8;
    localparam int unsigned STEP_CYCLES_DEF = 50000;

endpackage

// File: rtl/fader_channel.sv
// One fade channel: OFF/RISE/ON/FALL ramp of the brightness level plus the
// registered PWM comparator. Define LED_FADER_GAMMA_EN for squared duty.
module fader_channel
    import led_fader_pkg::*;
#(
    parameter int unsigned PWM_BITS = PWM_BITS_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req,
    input  logic                tick,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic [PWM_BITS-1:0] level,
    output logic                led
);

    localparam logic [PWM_BITS-1:0] MAX    = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] MAX_M1 = MAX - PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0] ONE    = PWM_BITS'(1);

    fade_state_e         state;
    fade_state_e         state_next;
    logic [PWM_BITS-1:0] level_next;
    logic [PWM_BITS-1:0] duty;
    logic                led_next;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= OFF;
        end else begin
            state <= state_next;
        end
    end

    // Next state: a request change always wins over completing the ramp
    always_comb begin
        state_next = state;
        case (state)
            OFF:  if (req) state_next = RISE;
            RISE: begin
                if (!req)                         state_next = FALL;
                else if (tick && level >= MAX_M1) state_next = ON;
            end
            ON:   if (!req) state_next = FALL;
            FALL: begin
                if (req)                      state_next = RISE;
                else if (tick && level <= ONE) state_next = OFF;
            end
            default: state_next = OFF;
        endcase
    end

    // Level steps follow the registered state, so a reversal on a tick
    // still moves once in the old direction
    always_comb begin
        level_next = level;
        if (tick) begin
            case (state)
                RISE:    if (level != MAX)      level_next = level + ONE;
                FALL:    if (level != '0)       level_next = level - ONE;
                default: level_next = level;
            endcase
        end
        led_next = (duty == MAX) || (duty > pwm_cnt);
    end

`ifdef LED_FADER_GAMMA_EN
    logic [2*PWM_BITS-1:0] sq;
    logic [PWM_BITS-1:0]   gamma;

    always_comb begin
        sq    = (2*PWM_BITS)'(level) * (2*PWM_BITS)'(level);
        gamma = (level == MAX) ? MAX : sq[2*PWM_BITS-1:PWM_BITS];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty <= '0;
        end else begin
            duty <= gamma;
        end
    end
`else
    assign duty = level;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= '0;
            led   <= 1'b0;
        end else begin
            level <= level_next;
            led   <= led_next;
        end
    end

endmodule

// File: rtl/led_fader.sv
// Two-channel PWM fader behind the siren blinker; owns the input registers,
// shared step tick and PWM counter. Optional LED_FADER_GAMMA_EN squares duty.
module led_fader
    import led_fader_pkg::*;
#(
    parameter int unsigned PWM_BITS    = PWM_BITS_DEF,
    parameter int unsigned STEP_CYCLES = STEP_CYCLES_DEF
) (
    input  logic                CLOCK_50,
    input  logic                RESET_N,
    input  logic                LED_R_IN,
    input  logic                LED_B_IN,
    output logic                LED_R,
    output logic                LED_B,
    output logic [PWM_BITS-1:0] R_LEVEL,
    output logic [PWM_BITS-1:0] B_LEVEL
);

    localparam int unsigned       STEP_W    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);

    logic                req_r;
    logic                req_b;
    logic [STEP_W-1:0]   step_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                tick_c;

    assign tick_c = (step_cnt == STEP_LAST);

    // Input capture, step divider and free-running PWM ramp
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            req_r    <= 1'b0;
            req_b    <= 1'b0;
            step_cnt <= '0;
            pwm_cnt  <= '0;
        end else begin
            req_r    <= LED_R_IN;
            req_b    <= LED_B_IN;
            step_cnt <= tick_c ? '0 : step_cnt + STEP_W'(1);
            pwm_cnt  <= pwm_cnt + PWM_BITS'(1);
        end
    end

    fader_channel #(.PWM_BITS(PWM_BITS)) u_red (
        .clk     (CLOCK_50),
        .rst_n   (RESET_N),
        .req     (req_r),
        .tick    (tick_c),
        .pwm_cnt (pwm_cnt),
        .level   (R_LEVEL),
        .led     (LED_R)
    );

    fader_channel #(.PWM_BITS(PWM_BITS)) u_blue (
        .clk     (CLOCK_50),
        .rst_n   (RESET_N),
        .req     (req_b),
        .tick    (tick_c),
        .pwm_cnt (pwm_cnt),
        .level   (B_LEVEL),
        .led     (LED_B)
    );

endmodule

// File: tb/tb_led_fader.sv
// Self-checking bench for led_fader (PWM_BITS=4, STEP_CYCLES=4): phase table
// with hand-derived levels, cycle-level reference model, async reset, random runs.
module tb_led_fader;

    localparam int unsigned PB   = 4;
    localparam int          STEP = 4;
    localparam int          MAXL = 15;
    localparam int          PER  = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          r_in;
    logic          b_in;
    logic          led_r;
    logic          led_b;
    logic [PB-1:0] r_level;
    logic [PB-1:0] b_level;

    int n_cmp = 0;
    int n_err = 0;

    led_fader #(.PWM_BITS(PB), .STEP_CYCLES(STEP)) dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .LED_R_IN (r_in),
        .LED_B_IN (b_in),
        .LED_R    (led_r),
        .LED_B    (led_b),
        .R_LEVEL  (r_level),
        .B_LEVEL  (b_level)
    );

    always #5 clk = ~clk;

    // Reference: brightness moves toward the last-seen request one step per tick
    int m_cyc;
    int m_req  [2];
    int m_dir  [2];
    int m_lvl  [2];
    int m_duty [2];
    int m_led  [2];

    function automatic int gamma_of(input int l);
        return (l == MAXL) ? MAXL : (l * l) / PER;
    endfunction

    task automatic model_reset();
        m_cyc = 0;
        for (int c = 0; c < 2; c++) begin
            m_req[c] = 0; m_dir[c] = 0; m_lvl[c] = 0; m_duty[c] = 0; m_led[c] = 0;
        end
    endtask

    task automatic model_edge(input int r, input int b);
        int pwm;
        int tick;
        int d;
        int inp [2];
        pwm    = m_cyc % PER;
        tick   = ((m_cyc % STEP) == STEP - 1) ? 1 : 0;
        inp[0] = r;
        inp[1] = b;
        for (int c = 0; c < 2; c++) begin
`ifdef LED_FADER_GAMMA_EN
            d         = m_duty[c];
            m_duty[c] = gamma_of(m_lvl[c]);
`else
            d = m_lvl[c];
`endif
            m_led[c] = (d == MAXL || d > pwm) ? 1 : 0;
            if (tick != 0) begin
                if (m_dir[c] != 0) m_lvl[c] = (m_lvl[c] < MAXL) ? m_lvl[c] + 1 : MAXL;
                else               m_lvl[c] = (m_lvl[c] > 0) ? m_lvl[c] - 1 : 0;
            end
            m_dir[c] = m_req[c];
            m_req[c] = inp[c];
        end
        m_cyc++;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // One clock: drive, advance model on the edge, compare 1 ns later
    task automatic step(input logic r, input logic b);
        r_in = r;
        b_in = b;
        @(posedge clk);
        model_edge(int'(r), int'(b));
        #1;
        check("r_level", int'(r_level), m_lvl[0]);
        check("b_level", int'(b_level), m_lvl[1]);
        check("led_r",   int'(led_r),   m_led[0]);
        check("led_b",   int'(led_b),   m_led[1]);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_r_level"}, int'(r_level), 0);
        check({name, "_b_level"}, int'(b_level), 0);
        check({name, "_led_r"},   int'(led_r),   0);
        check({name, "_led_b"},   int'(led_b),   0);
    endtask

    typedef struct {
        logic r;
        logic b;
        int   cycles;
        int   exp_r;
        int   exp_b;
    } vec_t;

    vec_t vecs [7];

    initial begin
        // Phases from reset release; expected levels derived by hand
        vecs[0] = '{1'b1, 1'b0, 64, 15, 0};   // full rise, then held ON
        vecs[1] = '{1'b0, 1'b0, 64, 0,  0};   // full fall to OFF
        vecs[2] = '{1'b1, 1'b1, 28, 7,  7};   // both rising to 7
        vecs[3] = '{1'b0, 1'b1, 8,  5,  9};   // red reverses 7->6->5, blue keeps rising
        vecs[4] = '{1'b0, 1'b1, 2,  5,  9};   // align next reversal onto a tick
        vecs[5] = '{1'b1, 1'b1, 2,  4,  10};  // reversal on tick: one more step down
        vecs[6] = '{1'b1, 1'b1, 4,  5,  11};  // next tick in new direction

        rst_n = 1'b0;
        r_in  = 1'b0;
        b_in  = 1'b0;
        #22;
        check_all_zero("in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        for (int v = 0; v < 7; v++) begin
            for (int k = 0; k < vecs[v].cycles; k++) step(vecs[v].r, vecs[v].b);
            check($sformatf("phase%0d_r_level", v), int'(r_level), vecs[v].exp_r);
            check($sformatf("phase%0d_b_level", v), int'(b_level), vecs[v].exp_b);
        end

        // Mid-ramp async reset clears outputs before the next edge
        step(1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("held_reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Ramp red up to level 8 and dwell there a while via reversals is not
        // possible; instead walk to ON and watch full-level output stay high
        for (int k = 0; k < 70; k++) step(1'b1, 1'b0);
        check("restart_r_full", int'(r_level), MAXL);
        check("restart_led_r_on", int'(led_r), 1);

        // Randomised request patterns against the model
        for (int seg = 0; seg < 60; seg++) begin
            logic rr;
            logic bb;
            int   len;
            rr  = 1'($urandom_range(0, 1));
            bb  = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 40));
            for (int k = 0; k < len; k++) step(rr, bb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
